// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 byte stream to held arrow-key levels and a space-bar press pulse.
// Optional feature macro: KEY_WASD_EN (W/A/S/D letters OR into UP/LEFT/DOWN/RIGHT).
module ps2_key_decoder #(
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic [7:0] ps2_byte,
   input  logic       ps2_byte_valid,
   input  logic       clear_keys,
   output logic       UP,
   output logic       DOWN,
   output logic       LEFT,
   output logic       RIGHT,
   output logic       space_pulse
);
   localparam logic [1:0] S_IDLE    = 2'b00;
   localparam logic [1:0] S_EXT     = 2'b01;
   localparam logic [1:0] S_BRK     = 2'b10;
   localparam logic [1:0] S_EXT_BRK = 2'b11;
   localparam logic [25:0] TMO = 26'(TIMEOUT_CYCLES);
   // Bit 0 of the state marks an E0 prefix, bit 1 marks an F0 prefix.
   logic [1:0]  state_q, state_d;
   logic [3:0]  arr_q, arr_d;
   logic        held_q, held_d;
   logic        pulse_q, pulse_d;
   logic [25:0] cnt_q, cnt_d;
   logic        pfx, fin, ext, brk, clr, sp;
   logic [3:0]  arr_hit;
`ifdef KEY_WASD_EN
   logic [3:0]  wasd_q, wasd_d;
   logic [3:0]  wasd_hit;
`endif
   // Decode the incoming byte against the prefix state and update flags, counter and FSM.
   always_comb begin
      ext     = state_q[0];
      brk     = state_q[1];
      pfx     = (ps2_byte == 8'hF0) || (ps2_byte == 8'hE0 && state_q != S_BRK);
      fin     = ps2_byte_valid && !pfx;
      cnt_d   = ps2_byte_valid ? 26'd0 : (cnt_q == TMO ? cnt_q : cnt_q + 26'd1);
      clr     = clear_keys || ((TMO != 26'd0) && !ps2_byte_valid && cnt_d == TMO);
      arr_hit = {ps2_byte == 8'h75, ps2_byte == 8'h72, ps2_byte == 8'h6B, ps2_byte == 8'h74} & {4{fin && ext}};
      sp      = fin && !ext && ps2_byte == 8'h29;
      state_d = !ps2_byte_valid ? state_q :
                !pfx ? S_IDLE :
                ps2_byte == 8'hF0 ? (ext ? S_EXT_BRK : S_BRK) : (brk ? S_EXT_BRK : S_EXT);
      arr_d   = (arr_q & ~arr_hit) | (arr_hit & {4{!brk}});
      held_d  = sp ? !brk : held_q;
      pulse_d = sp && !brk && !held_q;
`ifdef KEY_WASD_EN
      wasd_hit = {ps2_byte == 8'h1D, ps2_byte == 8'h1B, ps2_byte == 8'h1C, ps2_byte == 8'h23} & {4{fin && !ext}};
      wasd_d   = clr ? 4'd0 : (wasd_q & ~wasd_hit) | (wasd_hit & {4{!brk}});
`endif
      if (clr) begin
         state_d = S_IDLE;
         arr_d   = 4'd0;
         held_d  = 1'b0;
         pulse_d = 1'b0;
      end
   end
   // State registers with asynchronous active-low reset.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         arr_q   <= 4'd0;
         held_q  <= 1'b0;
         pulse_q <= 1'b0;
         cnt_q   <= 26'd0;
`ifdef KEY_WASD_EN
         wasd_q  <= 4'd0;
`endif
      end else begin
         state_q <= state_d;
         arr_q   <= arr_d;
         held_q  <= held_d;
         pulse_q <= pulse_d;
         cnt_q   <= cnt_d;
`ifdef KEY_WASD_EN
         wasd_q  <= wasd_d;
`endif
      end
   end
`ifdef KEY_WASD_EN
   assign {UP, DOWN, LEFT, RIGHT} = arr_q | wasd_q;
`else
   assign {UP, DOWN, LEFT, RIGHT} = arr_q;
`endif
   assign space_pulse = pulse_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed self-checking bench for ps2_key_decoder (TIMEOUT_CYCLES=100).
module tb_ps2_key_decoder;
   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] ps2_byte = 8'h00;
   logic       valid = 1'b0;
   logic       clear_keys = 1'b0;
   logic       up, down, left, right, space_pulse;
   int         errs = 0;
   int         checks = 0;
   int         pcnt = 0;
   int         p0;

   ps2_key_decoder #(.TIMEOUT_CYCLES(100)) dut (
      .CLOCK_50(clk), .resetn(resetn), .ps2_byte(ps2_byte), .ps2_byte_valid(valid),
      .clear_keys(clear_keys), .UP(up), .DOWN(down), .LEFT(left), .RIGHT(right),
      .space_pulse(space_pulse)
   );

   always #5 clk = ~clk;

   // Count cycles with space_pulse high, sampled mid-cycle.
   always @(negedge clk) if (space_pulse) pcnt++;

   task automatic chk(input string tag, input logic [4:0] exp);
      logic [4:0] got;
      got = {up, down, left, right, space_pulse};
      checks++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s got=%b expected=%b (UP DOWN LEFT RIGHT SPACE)", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic clr = 1'b0);
      @(negedge clk);
      ps2_byte   = b;
      valid      = 1'b1;
      clear_keys = clr;
      @(negedge clk);
      valid      = 1'b0;
      clear_keys = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_outputs", 5'b00000);
      resetn = 1'b1;
      send(8'hE0);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      send(8'h75);
      chk("reset_mid_seq", 5'b00000);
      send(8'hE0); send(8'h75);
      chk("up_make", 5'b10000);
      for (int i = 0; i < 3; i++) begin
         send(8'hE0); send(8'h75);
         chk("up_repeat", 5'b10000);
      end
      send(8'hAA);
      chk("aa_no_change", 5'b10000);
      send(8'hE0); send(8'hF0);
      chk("up_pre_break", 5'b10000);
      send(8'h75);
      chk("up_break", 5'b00000);
      send(8'hE0); send(8'h6B);
      send(8'hE0); send(8'h74);
      chk("left_right_held", 5'b00110);
      send(8'hE0); send(8'hF0); send(8'h6B);
      chk("left_break", 5'b00010);
      send(8'hE0); send(8'hF0); send(8'h74);
      chk("right_break", 5'b00000);
      @(negedge clk);
      ps2_byte = 8'hE0; valid = 1'b1;
      @(negedge clk);
      ps2_byte = 8'h72;
      @(negedge clk);
      valid = 1'b0;
      chk("b2b_down_make", 5'b01000);
      send(8'hE0); send(8'hF0); send(8'h72);
      chk("down_break", 5'b00000);
      p0 = pcnt;
      send(8'h29);
      chk("space_first", 5'b00001);
      send(8'h29);
      chk("space_rep1", 5'b00000);
      send(8'h29);
      chk("space_rep2", 5'b00000);
      send(8'hF0); send(8'h29);
      chk("space_break", 5'b00000);
      send(8'h29);
      chk("space_second", 5'b00001);
      repeat (2) @(negedge clk);
      checks++;
      assert (pcnt - p0 === 2) else begin
         errs++;
         $error("FAIL space_pulse_count got=%0d expected=2", pcnt - p0);
      end
      send(8'hF0); send(8'h29);
      send(8'hE0); send(8'h75, 1'b1);
      chk("clear_drops_byte", 5'b00000);
      send(8'h75);
      chk("clear_fsm_idle", 5'b00000);
      send(8'hE0); send(8'h6B);
      chk("left_before_clear", 5'b00100);
      @(negedge clk); clear_keys = 1'b1;
      @(negedge clk); clear_keys = 1'b0;
      chk("clear_held", 5'b00000);
      send(8'h29, 1'b1);
      chk("clear_kills_pulse", 5'b00000);
      send(8'h29);
      chk("space_after_clear", 5'b00001);
      send(8'hF0); send(8'h29);
`ifdef KEY_WASD_EN
      send(8'h1D);
      chk("w_make", 5'b10000);
      send(8'hF0); send(8'h1D);
      chk("w_break", 5'b00000);
`else
      send(8'h1D);
      chk("w_unmapped", 5'b00000);
      send(8'hF0); send(8'h1D);
      chk("w_break_unmapped", 5'b00000);
`endif
      send(8'hE0); send(8'h72);
      repeat (99) @(negedge clk);
      chk("timeout_cycle99", 5'b01000);
      @(negedge clk);
      chk("timeout_cycle100", 5'b00000);
      send(8'h72);
      chk("timeout_fsm_idle", 5'b00000);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Converts the PS/2 keyboard byte stream (scan code set 2) into held-key levels for the arrow keys and a one-cycle start pulse for the space bar. It sits directly upstream of the ship movement control path: its `UP`/`DOWN`/`LEFT`/`RIGHT` outputs drive that FSM's key inputs. The ship FSM waits for key release, so these outputs must reflect true make/break state, not per-byte strobes.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 50_000_000. Idle cycles with no byte before all held flags are force-cleared (1 s at 50 MHz). A value of 0 disables the timeout.

Ports:
- `CLOCK_50`  in  1  system clock, 50 MHz.
- `resetn`  in  1  reset. One clock; reset is asynchronous and active-low.
- `ps2_byte`  in  8  received byte from the PS/2 receiver.
- `ps2_byte_valid`  in  1  one-cycle strobe; `ps2_byte` is valid while high.
- `clear_keys`  in  1  synchronous clear of all held flags and the FSM (driven by new-game).
- `UP`, `DOWN`, `LEFT`, `RIGHT`  out  1 each  key currently held.
- `space_pulse`  out  1  one-cycle pulse on the space bar's press edge.

## Operation

- Decode FSM states:
  - `S_IDLE`.
  - `S_EXT`: `E0` received.
  - `S_BRK`: `F0` received.
  - `S_EXT_BRK`: `E0 F0` received.
- FSM transitions, evaluated only on `ps2_byte_valid`:
  - `S_IDLE`: `E0` -> `S_EXT`; `F0` -> `S_BRK`; any other byte -> make of a base code, stay in `S_IDLE`.
  - `S_EXT`: `F0` -> `S_EXT_BRK`; `E0` -> stay; other -> make of an extended code, go to `S_IDLE`.
  - `S_BRK`: `F0` -> stay; other -> break of a base code, go to `S_IDLE`.
  - `S_EXT_BRK`: `E0`/`F0` -> stay; other -> break of an extended code, go to `S_IDLE`.
- Extended map:
  - `75` = UP, `72` = DOWN, `6B` = LEFT, `74` = RIGHT.
  - A make sets the flag; a break clears it.
- Base map:
  - `29` = space.
  - Space make sets `space_held`. `space_pulse` fires only if `space_held` was 0, so typematic repeats do not re-pulse.
  - Space break clears `space_held`.
- Unmapped codes complete their sequence with no effect. This covers `E1` pause bytes and `AA`, `FA`, `FE`, `EE`, `00`, `FF`.
- Typematic repeat of a held key re-sets its flag, which is already set; there is no output change.
- Multiple arrow flags may be high together; prioritisation is done downstream.
- Timeout counter:
  - 26 bits.
  - Reloads to 0 on every `ps2_byte_valid`. Otherwise it increments, saturating at `TIMEOUT_CYCLES`.
  - On reaching `TIMEOUT_CYCLES`, the block clears all flags and `space_held`, and the FSM returns to `S_IDLE`.
  - This recovers from a lost break code; a held key repeats well inside 1 s.

## Timing

- Reset (async, `resetn` = 0):
  - FSM to `S_IDLE`; all flags, `space_held` and the counter to 0.
  - All outputs 0.
- Latency:
  - A flag changes on the clock edge that samples the final byte of its sequence with valid high. The output is visible the next cycle.
  - `space_pulse` is high for exactly one cycle, the cycle after the `29` make is sampled.
- `clear_keys`:
  - Acts on the next edge.
  - If it coincides with `ps2_byte_valid`, the clear wins and the byte is dropped.
  - The FSM goes to `S_IDLE` and `space_pulse` is suppressed.
- Timeout and byte in the same cycle: the byte is processed and the counter reloads.
- Back-to-back `ps2_byte_valid` on consecutive cycles must be accepted.

## Configuration

- `KEY_WASD_EN`:
  - When defined, base codes `1D`=W, `1C`=A, `1B`=S, `23`=D drive separate W/A/S/D held flags.
  - Each output is the OR of its arrow flag and its letter flag: W with `UP`, A with `LEFT`, S with `DOWN`, D with `RIGHT`.
- When `KEY_WASD_EN` is undefined, those codes are unmapped and only the arrow keys drive the outputs.

## Test plan

- Reset mid-sequence: release after `E0` has been sent, then send `75`. `UP` must remain 0, because a base `75` is unmapped.
- Hold and repeat:
  - Send `E0 75` -> `UP`=1 one cycle after the `75` strobe.
  - Send `E0 75` ×3 (repeats) -> `UP` stays 1.
  - Send `E0 F0 75` -> `UP`=0.
- Overlapping keys:
  - Send `E0 6B`, `E0 74` -> `LEFT`=`RIGHT`=1.
  - Send `E0 F0 6B` -> `LEFT`=0, `RIGHT`=1.
- Space:
  - Send `29 29 29 F0 29 29` -> exactly two single-cycle `space_pulse` pulses, one at the first `29` and one at the final `29`.
  - Send `AA` -> no output change.
- Timeout: with `TIMEOUT_CYCLES`=100, send `E0 72` and then nothing. `DOWN` is 1 through cycle 99 after the strobe and falls to 0 at cycle 100.
- Clear and WASD:
  - `clear_keys` in the same cycle as the `75` strobe of `E0 75` -> `UP` stays 0.
  - With `KEY_WASD_EN`, send `1D` -> `UP`=1, then `F0 1D` -> `UP`=0.
